uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm_if.sv | 30 +++
 rtl/uart_rx_fsm.sv | 158 +++++++++++++++
 tb/tb_uart_rx_fsm.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// Handshake bundle between the UART receive controller and its line, checkers,
// sampler and deserializer. The slave side is the controller itself.
interface uart_rx_fsm_if;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       deser_en;
  logic       data_valid;

  modport master (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
           stp_chk_en, deser_en, data_valid
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
           stp_chk_en, deser_en, data_valid
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive controller: oversampled bit timing, check/shift strobes and the
// frame-good pulse. Prescale and PAR_EN are captured when a frame leaves IDLE.
module uart_rx_fsm (
  input logic           CLK,
  input logic           RST,
  uart_rx_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state_r;
  logic [5:0] presc_r;
  logic       par_en_r;
  logic       err_r;
  logic [5:0] edge_cnt_r;
  logic [3:0] bit_cnt_r;
  logic       dat_samp_en_r;
  logic       strt_chk_en_r;
  logic       par_chk_en_r;
  logic       stp_chk_en_r;
  logic       deser_en_r;
  logic       data_valid_r;

  logic       prescale_ok_s;
  logic [5:0] pre_chk_s;
  logic [5:0] last_s;
  logic       last_edge_s;
  logic       pre_chk_hit_s;
  logic [5:0] edge_inc_s;

  assign prescale_ok_s = (bus.Prescale == 6'd8) || (bus.Prescale == 6'd16) ||
                         (bus.Prescale == 6'd32);
  // Strobes are registered, so they are armed one edge ahead of the check edge.
  assign pre_chk_s     = {1'b0, presc_r[5:1]} + 6'd1;
  assign last_s        = presc_r - 6'd1;
  assign last_edge_s   = (edge_cnt_r == last_s);
  assign pre_chk_hit_s = (edge_cnt_r == pre_chk_s);
  assign edge_inc_s    = edge_cnt_r + 6'd1;

  // Frame state machine with registered counters and strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r       <= IDLE;
      presc_r       <= 6'd0;
      par_en_r      <= 1'b0;
      err_r         <= 1'b0;
      edge_cnt_r    <= 6'd0;
      bit_cnt_r     <= 4'd0;
      dat_samp_en_r <= 1'b0;
      strt_chk_en_r <= 1'b0;
      par_chk_en_r  <= 1'b0;
      stp_chk_en_r  <= 1'b0;
      deser_en_r    <= 1'b0;
      data_valid_r  <= 1'b0;
    end else begin
      strt_chk_en_r <= (state_r == START)  && pre_chk_hit_s;
      deser_en_r    <= (state_r == DATA)   && pre_chk_hit_s;
      par_chk_en_r  <= (state_r == PARITY) && pre_chk_hit_s;
      stp_chk_en_r  <= (state_r == STOP)   && pre_chk_hit_s;
      data_valid_r  <= 1'b0;

      case (state_r)
        IDLE: begin
          edge_cnt_r <= 6'd0;
          bit_cnt_r  <= 4'd0;
          if (!bus.RX_IN && prescale_ok_s) begin
            state_r       <= START;
            presc_r       <= bus.Prescale;
            par_en_r      <= bus.PAR_EN;
            err_r         <= 1'b0;
            dat_samp_en_r <= 1'b1;
          end else begin
            dat_samp_en_r <= 1'b0;
          end
        end

        START: begin
          if (last_edge_s) begin
            edge_cnt_r <= 6'd0;
            bit_cnt_r  <= 4'd0;
            if (bus.strt_glitch) begin
              state_r       <= IDLE;
              dat_samp_en_r <= 1'b0;
            end else begin
              state_r <= DATA;
            end
          end else begin
            edge_cnt_r <= edge_inc_s;
          end
        end

        DATA: begin
          if (last_edge_s) begin
            edge_cnt_r <= 6'd0;
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_r <= 4'd0;
              state_r   <= par_en_r ? PARITY : STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end else begin
            edge_cnt_r <= edge_inc_s;
          end
        end

        PARITY: begin
          if (last_edge_s) begin
            edge_cnt_r <= 6'd0;
            err_r      <= bus.par_err;
            state_r    <= STOP;
          end else begin
            edge_cnt_r <= edge_inc_s;
          end
        end

        STOP: begin
          if (last_edge_s) begin
            edge_cnt_r   <= 6'd0;
            data_valid_r <= !bus.stp_err && !err_r;
            // A low line here is the next start bit; timing stays as latched.
            if (!bus.RX_IN) begin
              state_r <= START;
              err_r   <= 1'b0;
            end else begin
              state_r       <= IDLE;
              dat_samp_en_r <= 1'b0;
            end
          end else begin
            edge_cnt_r <= edge_inc_s;
          end
        end

        default: begin
          state_r       <= IDLE;
          edge_cnt_r    <= 6'd0;
          bit_cnt_r     <= 4'd0;
          dat_samp_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.edge_cnt    = edge_cnt_r;
  assign bus.bit_cnt     = bit_cnt_r;
  assign bus.dat_samp_en = dat_samp_en_r;
  assign bus.strt_chk_en = strt_chk_en_r;
  assign bus.par_chk_en  = par_chk_en_r;
  assign bus.stp_chk_en  = stp_chk_en_r;
  assign bus.deser_en    = deser_en_r;
  assign bus.data_valid  = data_valid_r;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: expected strobe timing is derived from the
// cycle index since the START entry edge (cycle 0).
module tb_uart_rx_fsm;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  uart_rx_fsm_if bus ();

  uart_rx_fsm dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}
  function automatic logic [5:0] outs();
    return {bus.dat_samp_en, bus.strt_chk_en, bus.deser_en,
            bus.par_chk_en, bus.stp_chk_en, bus.data_valid};
  endfunction

  task automatic start_frame(input int p, input bit par);
    bus.Prescale = 6'(p);
    bus.PAR_EN   = par;
    bus.RX_IN    = 1'b0;
    tick();
  endtask

  // Walks one frame from cycle 0 to cycle (10+par)*p, perturbing the line and
  // the timing inputs mid-frame; those must have no effect.
  task automatic run_frame(input int p, input bit par, input bit pe, input bit se,
                           input bit dv0, input bit b2b, input bit exp_dv);
    int n;
    int slot;
    int off;
    int chkp;
    logic [5:0] e;
    n    = (10 + int'(par)) * p;
    chkp = p / 2 + 2;
    bus.par_err     = pe;
    bus.stp_err     = se;
    bus.strt_glitch = 1'b0;
    for (int c = 0; c < n; c++) begin
      slot = c / p;
      off  = c % p;
      e = {1'b1,
           (slot == 0) && (off == chkp),
           (slot >= 1) && (slot <= 8) && (off == chkp),
           par && (slot == 9) && (off == chkp),
           (slot == 9 + int'(par)) && (off == chkp),
           (c == 0) && dv0};
      chk("frame_outs", 32'(outs()), 32'(e));
      chk("frame_edge_cnt", 32'(bus.edge_cnt), 32'(off));
      chk("frame_bit_cnt", 32'(bus.bit_cnt), ((slot >= 1) && (slot <= 8)) ? 32'(slot - 1) : 32'd0);
      bus.RX_IN = (c == n - 1) ? !b2b : (c % 3 != 0);
      if (c == 1) begin
        bus.Prescale = (p == 32) ? 6'd8 : 6'd32;
        bus.PAR_EN   = !par;
      end
      tick();
    end
    chk("frame_data_valid", 32'(bus.data_valid), 32'(exp_dv));
    chk("frame_samp_after", 32'(bus.dat_samp_en), 32'(b2b));
    chk("frame_edge_wrap", 32'(bus.edge_cnt), 32'd0);
    if (!b2b) begin
      tick();
      chk("frame_dv_single", 32'(outs()), 32'd0);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    RST             = 1'b0;
    bus.RX_IN       = 1'b1;
    bus.PAR_EN      = 1'b0;
    bus.Prescale    = 6'd8;
    bus.strt_glitch = 1'b0;
    bus.par_err     = 1'b0;
    bus.stp_err     = 1'b0;

    // Reset state, with a low line that must not start a frame.
    bus.RX_IN = 1'b0;
    repeat (3) tick();
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_edge", 32'(bus.edge_cnt), 32'd0);
    chk("rst_bit", 32'(bus.bit_cnt), 32'd0);
    bus.RX_IN = 1'b1;
    RST = 1'b1;
    repeat (3) tick();
    chk("idle_outs", 32'(outs()), 32'd0);

    // Clean Prescale=8 frame without parity.
    start_frame(8, 1'b0);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start glitch aborts the frame at cycle 8.
    start_frame(8, 1'b0);
    bus.strt_glitch = 1'b1;
    bus.RX_IN       = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk("glitch_edge", 32'(bus.edge_cnt), 32'(c));
      chk("glitch_outs", 32'(outs()), (c == 6) ? 32'h30 : 32'h20);
      tick();
    end
    bus.strt_glitch = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk("glitch_idle", 32'(outs()), 32'd0);
      chk("glitch_edge0", 32'(bus.edge_cnt), 32'd0);
      tick();
    end

    // Prescale=16 with parity: parity error suppresses data_valid, next frame clears it.
    start_frame(16, 1'b1);
    run_frame(16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    start_frame(16, 1'b1);
    run_frame(16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Stop error suppresses data_valid.
    start_frame(8, 1'b0);
    run_frame(8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames: second frame starts straight from STOP.
    start_frame(8, 1'b0);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Largest ratio.
    start_frame(32, 1'b0);
    run_frame(32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Illegal Prescale holds IDLE even with a low line.
    bus.Prescale = 6'd12;
    bus.RX_IN    = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("illegal_outs", 32'(outs()), 32'd0);
      chk("illegal_edge", 32'(bus.edge_cnt), 32'd0);
    end
    bus.RX_IN = 1'b1;
    tick();

    // Reset at cycle 40 of a frame.
    start_frame(8, 1'b0);
    repeat (40) tick();
    chk("mid_bit_cnt", 32'(bus.bit_cnt), 32'd4);
    chk("mid_samp", 32'(bus.dat_samp_en), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'd0);
    chk("async_rst_bit", 32'(bus.bit_cnt), 32'd0);
    chk("async_rst_edge", 32'(bus.edge_cnt), 32'd0);
    bus.RX_IN = 1'b1;
    repeat (2) tick();
    RST = 1'b1;
    tick();
    chk("post_rst_first", 32'(outs()), 32'd0);
    for (int c = 0; c < 100; c++) begin
      chk("post_rst_idle", 32'(outs()), 32'd0);
      chk("post_rst_edge", 32'(bus.edge_cnt), 32'd0);
      tick();
    end

    // A fresh start bit after reset is accepted.
    start_frame(8, 1'b0);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
